// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
//
// Pipelined pixel compositor that sits between the sprite/background engines
// and the VGA controller. Each pixel clock it takes NUM_LAYERS layer inputs
// (on flag + colour), resolves them by priority (layer 0 wins) and produces
// one registered rgb word two clocks later. It also keeps per-frame pairwise
// overlap flags for the game engine, published on every frame_start.
//
// Ports:
//   clk           pixel clock, shared with the VGA controller
//   clrn          asynchronous active-low reset
//   video_on      active display region, aligned with the layer inputs
//   frame_start   one-cycle pulse per frame (start of vertical blank)
//   layer_on      per-layer pixel-on flags
//   layer_color   packed colours, layer i at [i*COLOR_W +: COLOR_W]
//   layer_enable  runtime mask; 0 hides a layer and removes it from collision
//   rgb_out       composited colour (registered, 2-cycle latency)
//   rgb_valid     video_on delayed to line up with rgb_out
//   collide_flags bit [i*NUM_LAYERS+j] (i<j) set if layers i and j overlapped
//                 in the last completed frame
//   collide_irq   one-cycle pulse when freshly published flags are nonzero
// ---------------------------------------------------------------------------
module layer_compositor #(
  parameter int                 NUM_LAYERS = 5,
  parameter int                 COLOR_W    = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000,
  parameter bit                 KEY_EN     = 1'b1,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = 12'hF0F
) (
  input  logic                           clk,
  input  logic                           clrn,
  input  logic                           video_on,
  input  logic                           frame_start,
  input  logic [NUM_LAYERS-1:0]          layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0]  layer_color,
  input  logic [NUM_LAYERS-1:0]          layer_enable,
  output logic [COLOR_W-1:0]             rgb_out,
  output logic                           rgb_valid,
  output logic [NUM_LAYERS*NUM_LAYERS-1:0] collide_flags,
  output logic                           collide_irq
);

  logic [NUM_LAYERS-1:0]            vis;
  logic [NUM_LAYERS-1:0]            s1_vis;
  logic [NUM_LAYERS*COLOR_W-1:0]    s1_color;
  logic                             s1_video;
  logic [COLOR_W-1:0]               pick;
  logic [NUM_LAYERS*NUM_LAYERS-1:0] pair;
  logic [NUM_LAYERS*NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS*NUM_LAYERS-1:0] published;

  // A layer is visible only when it is on, enabled and not the key colour.
  always_comb begin
    vis = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      vis[i] = layer_on[i] & layer_enable[i] &
               !(KEY_EN && (layer_color[i*COLOR_W +: COLOR_W] == KEY_COLOR));
    end
  end

  // Stage 1: capture visibility, colours and video_on.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_vis   <= '0;
      s1_color <= '0;
      s1_video <= 1'b0;
    end else begin
      s1_vis   <= vis;
      s1_color <= layer_color;
      s1_video <= video_on;
    end
  end

  // Scanning from the lowest priority upwards lets layer 0 overwrite last.
  always_comb begin
    pick = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_vis[i]) pick = s1_color[i*COLOR_W +: COLOR_W];
    end
    if (!s1_video) pick = BG_COLOR;
  end

  // Stage 2: registered output.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rgb_out   <= BG_COLOR;
      rgb_valid <= 1'b0;
    end else begin
      rgb_out   <= pick;
      rgb_valid <= s1_video;
    end
  end

  // Upper-triangle overlap term of the stage-1 pixel; blanked outside the
  // active region so that off-screen sprite data never counts as a hit.
  always_comb begin
    pair = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      for (int j = i + 1; j < NUM_LAYERS; j++) begin
        pair[i*NUM_LAYERS + j] = s1_video & s1_vis[i] & s1_vis[j];
      end
    end
  end

  // The in-flight stage-1 pixel is folded into the publish so it is not
  // lost at the frame boundary.
  assign published = acc | pair;

  // Accumulate during the frame; frame_start publishes, clears and raises
  // the interrupt in one step, taking precedence over accumulation.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc           <= '0;
      collide_flags <= '0;
      collide_irq   <= 1'b0;
    end else if (frame_start) begin
      acc           <= '0;
      collide_flags <= published;
      collide_irq   <= |published;
    end else begin
      acc           <= published;
      collide_irq   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_layer_compositor
//
// Self-checking bench for layer_compositor. Two instances share the inputs:
// one with colour keying on (default build) and one with keying off. A
// pixel-level reference model predicts rgb_out/rgb_valid from the pixel
// presented one clock earlier and tracks frame overlaps as a pairs table.
// ---------------------------------------------------------------------------
module tb_layer_compositor;

  localparam int          NL  = 5;
  localparam int          CW  = 12;
  localparam logic [11:0] BG  = 12'h000;
  localparam logic [11:0] KEY = 12'hF0F;

  typedef struct packed {
    logic              v;
    logic              fs;
    logic [NL-1:0]     on;
    logic [NL-1:0]     en;
    logic [NL*CW-1:0]  col;
  } px_t;

  logic              clk = 1'b0;
  logic              clrn = 1'b1;
  logic              video_on = 1'b0;
  logic              frame_start = 1'b0;
  logic [NL-1:0]     layer_on = '0;
  logic [NL-1:0]     layer_enable = '0;
  logic [NL*CW-1:0]  layer_color = '0;

  logic [CW-1:0]     rgb_out, nk_rgb_out;
  logic              rgb_valid, nk_rgb_valid;
  logic [NL*NL-1:0]  collide_flags, nk_collide_flags;
  logic              collide_irq, nk_collide_irq;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: index 0 = keying off, index 1 = keying on.
  px_t              s1;
  bit               acc [2][NL][NL];
  bit               pub [2][NL][NL];
  logic [CW-1:0]    exp_rgb [2];
  logic [NL*NL-1:0] exp_flags [2];
  logic             exp_irq [2];
  logic             exp_valid;

  always #5 clk = ~clk;

  layer_compositor dut (
    .clk(clk), .clrn(clrn), .video_on(video_on), .frame_start(frame_start),
    .layer_on(layer_on), .layer_color(layer_color), .layer_enable(layer_enable),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid),
    .collide_flags(collide_flags), .collide_irq(collide_irq)
  );

  layer_compositor #(.KEY_EN(1'b0)) dut_nokey (
    .clk(clk), .clrn(clrn), .video_on(video_on), .frame_start(frame_start),
    .layer_on(layer_on), .layer_color(layer_color), .layer_enable(layer_enable),
    .rgb_out(nk_rgb_out), .rgb_valid(nk_rgb_valid),
    .collide_flags(nk_collide_flags), .collide_irq(nk_collide_irq)
  );

  function automatic logic [NL*CW-1:0] cols(input logic [11:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  function automatic px_t mkpx(input logic v, fs, input logic [NL-1:0] on, en,
                               input logic [NL*CW-1:0] col);
    px_t p;
    p.v = v; p.fs = fs; p.on = on; p.en = en; p.col = col;
    return p;
  endfunction

  function automatic bit visible(input int i, input int k);
    return s1.on[i] && s1.en[i] && !(k == 1 && s1.col[i*CW +: CW] == KEY);
  endfunction

  // Highest-priority visible layer of the pixel held in the model's stage.
  function automatic logic [CW-1:0] resolve(input int k);
    if (!s1.v) return BG;
    for (int i = 0; i < NL; i++) if (visible(i, k)) return s1.col[i*CW +: CW];
    return BG;
  endfunction

  task automatic model_reset();
    s1 = '0;
    exp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++)
        for (int j = 0; j < NL; j++) begin
          acc[k][i][j] = 1'b0;
          pub[k][i][j] = 1'b0;
        end
      exp_rgb[k] = BG; exp_flags[k] = '0; exp_irq[k] = 1'b0;
    end
  endtask

  // Present one pixel, clock it, advance the model, then step off the edge.
  task automatic drive_cycle(input px_t p);
    bit hit;
    video_on = p.v; frame_start = p.fs; layer_on = p.on;
    layer_enable = p.en; layer_color = p.col;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_rgb[k] = resolve(k);
      for (int i = 0; i < NL; i++)
        for (int j = i + 1; j < NL; j++) begin
          hit = s1.v && visible(i, k) && visible(j, k);
          if (p.fs) pub[k][i][j] = acc[k][i][j] | hit;
          else      acc[k][i][j] = acc[k][i][j] | hit;
        end
      if (p.fs)
        for (int i = 0; i < NL; i++)
          for (int j = 0; j < NL; j++) acc[k][i][j] = 1'b0;
      exp_flags[k] = '0;
      for (int i = 0; i < NL; i++)
        for (int j = i + 1; j < NL; j++)
          if (pub[k][i][j]) exp_flags[k][i*NL + j] = 1'b1;
      exp_irq[k] = p.fs && (exp_flags[k] != '0);
    end
    exp_valid = s1.v;
    s1 = p;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2 clrn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      frame_start = (k == 1);
      n_vec++; if (rgb_out !== BG) begin n_fail++; $display("[TB] FAIL reset rgb_out step %0d: got %h expected %h", k, rgb_out, BG); end
      n_vec++; if (rgb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset rgb_valid step %0d: got %b expected 0", k, rgb_valid); end
      n_vec++; if (collide_flags !== '0) begin n_fail++; $display("[TB] FAIL reset collide_flags step %0d: got %h expected 0", k, collide_flags); end
      n_vec++; if (collide_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset collide_irq step %0d: got %b expected 0", k, collide_irq); end
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    clrn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_cycle('0);
      n_vec++; if (rgb_out !== BG) begin n_fail++; $display("[TB] FAIL idle rgb_out step %0d: got %h expected %h", k, rgb_out, BG); end
      n_vec++; if (rgb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle rgb_valid step %0d: got %b expected 0", k, rgb_valid); end
      n_vec++; if (collide_flags !== '0) begin n_fail++; $display("[TB] FAIL idle collide_flags step %0d: got %h expected 0", k, collide_flags); end
    end
  endtask

  task automatic test_priority();
    px_t seq[4];
    logic [NL*CW-1:0] c;
    c = cols(12'h123, 12'hF00, 12'h0F0, 12'h456, 12'h789);
    seq[0] = mkpx(1, 0, 5'b00110, 5'b11111, c);
    seq[1] = mkpx(1, 0, 5'b00110, 5'b11101, c);
    seq[2] = mkpx(1, 0, 5'b00000, 5'b11111, c);
    seq[3] = mkpx(1, 0, 5'b00000, 5'b11111, c);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(seq[k]);
      n_vec++; if (rgb_out !== exp_rgb[1]) begin n_fail++; $display("[TB] FAIL priority rgb_out step %0d: got %h expected %h", k, rgb_out, exp_rgb[1]); end
      n_vec++; if (rgb_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL priority rgb_valid step %0d: got %b expected %b", k, rgb_valid, exp_valid); end
      if (k == 1) begin
        n_vec++; if (rgb_out !== 12'hF00 || rgb_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL priority latency: got %h/%b expected f00/1", rgb_out, rgb_valid); end
      end
      if (k == 2) begin
        n_vec++; if (rgb_out !== 12'h0F0) begin n_fail++; $display("[TB] FAIL priority enable mask: got %h expected 0f0", rgb_out); end
      end
    end
  endtask

  task automatic test_color_key();
    px_t seq[2];
    seq[0] = mkpx(1, 0, 5'b10001, 5'b11111, cols(KEY, 12'h111, 12'h222, 12'h333, 12'h00F));
    seq[1] = mkpx(1, 0, 5'b00000, 5'b11111, '0);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(seq[k]);
      n_vec++; if (rgb_out !== exp_rgb[1]) begin n_fail++; $display("[TB] FAIL key rgb_out step %0d: got %h expected %h", k, rgb_out, exp_rgb[1]); end
      n_vec++; if (nk_rgb_out !== exp_rgb[0]) begin n_fail++; $display("[TB] FAIL nokey rgb_out step %0d: got %h expected %h", k, nk_rgb_out, exp_rgb[0]); end
      if (k == 1) begin
        n_vec++; if (rgb_out !== 12'h00F) begin n_fail++; $display("[TB] FAIL key transparent: got %h expected 00f", rgb_out); end
        n_vec++; if (nk_rgb_out !== 12'hF0F) begin n_fail++; $display("[TB] FAIL nokey opaque: got %h expected f0f", nk_rgb_out); end
      end
    end
  endtask

  task automatic test_collision();
    px_t seq[8];
    px_t idle;
    idle = mkpx(1, 0, 5'b00000, 5'b11111, '0);
    seq[0] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[1] = mkpx(1, 0, 5'b01010, 5'b11111, cols(12'h100, 12'h200, 12'h300, 12'h400, 12'h500));
    seq[2] = idle;
    seq[3] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[4] = idle;
    seq[5] = idle;
    seq[6] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[7] = idle;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(seq[k]);
      n_vec++; if (collide_flags !== exp_flags[1]) begin n_fail++; $display("[TB] FAIL collision flags step %0d: got %h expected %h", k, collide_flags, exp_flags[1]); end
      n_vec++; if (collide_irq !== exp_irq[1]) begin n_fail++; $display("[TB] FAIL collision irq step %0d: got %b expected %b", k, collide_irq, exp_irq[1]); end
      if (k == 3 || k == 4) begin
        n_vec++; if (collide_flags !== 25'h100 || collide_irq !== (k == 3)) begin n_fail++; $display("[TB] FAIL collision L1/L3 step %0d: got %h/%b expected 100/%b", k, collide_flags, collide_irq, (k == 3)); end
      end
      if (k == 6) begin
        n_vec++; if (collide_flags !== '0 || collide_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL collision clean frame: got %h/%b expected 0/0", collide_flags, collide_irq); end
      end
    end
  endtask

  task automatic test_boundary();
    px_t seq[8];
    px_t idle;
    logic [NL*CW-1:0] c;
    c = cols(12'h00A, 12'h0B0, 12'hC00, 12'h0DD, 12'hE0E);
    idle = mkpx(1, 0, 5'b00000, 5'b11111, '0);
    seq[0] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[1] = mkpx(1, 0, 5'b10001, 5'b11111, c);
    seq[2] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[3] = idle;
    seq[4] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[5] = mkpx(0, 0, 5'b00110, 5'b11111, c);
    seq[6] = idle;
    seq[7] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(seq[k]);
      n_vec++; if (collide_flags !== exp_flags[1]) begin n_fail++; $display("[TB] FAIL boundary flags step %0d: got %h expected %h", k, collide_flags, exp_flags[1]); end
      n_vec++; if (collide_irq !== exp_irq[1]) begin n_fail++; $display("[TB] FAIL boundary irq step %0d: got %b expected %b", k, collide_irq, exp_irq[1]); end
      if (k == 2) begin
        n_vec++; if (collide_flags !== 25'h10 || collide_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL boundary in-flight pixel: got %h/%b expected 10/1", collide_flags, collide_irq); end
      end
      if (k == 4 || k == 7) begin
        n_vec++; if (collide_flags !== '0 || collide_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL boundary empty publish step %0d: got %h/%b expected 0/0", k, collide_flags, collide_irq); end
      end
    end
  endtask

  task automatic test_back_to_back();
    px_t seq[5];
    logic [NL*CW-1:0] c;
    c = cols(12'h001, 12'h002, 12'h003, 12'h004, 12'h005);
    seq[0] = mkpx(1, 0, 5'b01010, 5'b11111, c);
    seq[1] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[2] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[3] = mkpx(1, 1, 5'b00101, 5'b11111, c);
    seq[4] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(seq[k]);
      n_vec++; if (collide_flags !== exp_flags[1]) begin n_fail++; $display("[TB] FAIL b2b flags step %0d: got %h expected %h", k, collide_flags, exp_flags[1]); end
      n_vec++; if (collide_irq !== exp_irq[1]) begin n_fail++; $display("[TB] FAIL b2b irq step %0d: got %b expected %b", k, collide_irq, exp_irq[1]); end
      if (k == 1) begin
        n_vec++; if (collide_flags !== 25'h100) begin n_fail++; $display("[TB] FAIL b2b first publish: got %h expected 100", collide_flags); end
      end
      if (k == 2) begin
        n_vec++; if (collide_flags !== '0 || collide_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b second publish: got %h/%b expected 0/0", collide_flags, collide_irq); end
      end
      if (k == 4) begin
        n_vec++; if (collide_flags !== 25'h4 || collide_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b L0/L2 publish: got %h/%b expected 4/1", collide_flags, collide_irq); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    px_t seq[4];
    px_t idle;
    logic [NL*CW-1:0] c;
    c = cols(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0, 12'h0E0);
    idle = mkpx(1, 0, 5'b00000, 5'b11111, '0);
    seq[0] = mkpx(1, 0, 5'b00101, 5'b11111, c);
    seq[1] = mkpx(1, 1, 5'b00000, 5'b11111, '0);
    seq[2] = mkpx(1, 0, 5'b00101, 5'b11111, c);
    seq[3] = idle;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(seq[k]);
      n_vec++; if (collide_flags !== exp_flags[1]) begin n_fail++; $display("[TB] FAIL midreset pre flags step %0d: got %h expected %h", k, collide_flags, exp_flags[1]); end
    end
    video_on = 1'b0; frame_start = 1'b0; layer_on = '0; layer_enable = '0; layer_color = '0;
    #2 clrn = 1'b0;
    model_reset();
    #1;
    n_vec++; if (collide_flags !== '0) begin n_fail++; $display("[TB] FAIL midreset flags cleared: got %h expected 0", collide_flags); end
    n_vec++; if (rgb_out !== BG || rgb_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset outputs: got %h/%b expected %h/0", rgb_out, rgb_valid, BG); end
    @(posedge clk); @(posedge clk); #1;
    clrn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_cycle((k == 2) ? mkpx(1, 1, 5'b00000, 5'b11111, '0) : idle);
      n_vec++; if (collide_flags !== exp_flags[1]) begin n_fail++; $display("[TB] FAIL midreset post flags step %0d: got %h expected %h", k, collide_flags, exp_flags[1]); end
      n_vec++; if (collide_irq !== exp_irq[1]) begin n_fail++; $display("[TB] FAIL midreset post irq step %0d: got %b expected %b", k, collide_irq, exp_irq[1]); end
    end
    n_vec++; if (collide_flags !== '0 || collide_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset partial publish: got %h/%b expected 0/0", collide_flags, collide_irq); end
  endtask

  task automatic test_random();
    px_t p;
    for (int k = 0; k < 600; k++) begin
      p.v  = ($urandom_range(0, 9) != 0);
      p.fs = ($urandom_range(0, 24) == 0);
      p.on = 5'($urandom);
      p.en = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
      for (int i = 0; i < NL; i++)
        p.col[i*CW +: CW] = ($urandom_range(0, 4) == 0) ? KEY : 12'($urandom);
      drive_cycle(p);
      n_vec++; if (rgb_out !== exp_rgb[1]) begin n_fail++; $display("[TB] FAIL random rgb_out step %0d: got %h expected %h", k, rgb_out, exp_rgb[1]); end
      n_vec++; if (rgb_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL random rgb_valid step %0d: got %b expected %b", k, rgb_valid, exp_valid); end
      n_vec++; if (collide_flags !== exp_flags[1]) begin n_fail++; $display("[TB] FAIL random flags step %0d: got %h expected %h", k, collide_flags, exp_flags[1]); end
      n_vec++; if (collide_irq !== exp_irq[1]) begin n_fail++; $display("[TB] FAIL random irq step %0d: got %b expected %b", k, collide_irq, exp_irq[1]); end
      n_vec++; if (nk_rgb_out !== exp_rgb[0]) begin n_fail++; $display("[TB] FAIL random nokey rgb_out step %0d: got %h expected %h", k, nk_rgb_out, exp_rgb[0]); end
      n_vec++; if (nk_rgb_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL random nokey rgb_valid step %0d: got %b expected %b", k, nk_rgb_valid, exp_valid); end
      n_vec++; if (nk_collide_flags !== exp_flags[0]) begin n_fail++; $display("[TB] FAIL random nokey flags step %0d: got %h expected %h", k, nk_collide_flags, exp_flags[0]); end
      n_vec++; if (nk_collide_irq !== exp_irq[0]) begin n_fail++; $display("[TB] FAIL random nokey irq step %0d: got %b expected %b", k, nk_collide_irq, exp_irq[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_color_key();
    test_collision();
    test_boundary();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined pixel compositor between the sprite/background engines and vgac.
- Takes NUM_LAYERS per-pixel layer inputs, each an on flag and a colour, and outputs one priority-resolved rgb word per pixel clock. Layer 0 has the highest priority.
- Additions over a flat priority mux: runtime layer enable mask, optional transparent colour key, fixed 2-cycle pipeline, and per-frame pairwise collision flags latched at frame boundaries for the game engine (e.g. bullet-vs-tank).

Parameters:
- NUM_LAYERS, 5, number of layer inputs (2..8); index 0 = highest priority.
- COLOR_W, 12, colour width per layer and output.
- BG_COLOR, 12'h000, output colour when no layer is visible or video_on is low.
- KEY_EN, 1, 1 = enable colour-key transparency.
- KEY_COLOR, 12'hF0F, colour treated as transparent when KEY_EN = 1.

Ports:
- clk  in  1  pixel clock (same clock as vgac).
- clrn  in  1  asynchronous active-low reset.
- video_on  in  1  active display region, aligned with the layer inputs.
- frame_start  in  1  single-cycle pulse once per frame (start of vertical blank).
- layer_on  in  NUM_LAYERS  per-layer pixel-on flag.
- layer_color  in  NUM_LAYERS*COLOR_W  packed colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_enable  in  NUM_LAYERS  runtime mask; 0 hides the layer and excludes it from collision.
- rgb_out  out  COLOR_W  composited colour, registered.
- rgb_valid  out  1  video_on delayed to match rgb_out.
- collide_flags  out  NUM_LAYERS*NUM_LAYERS  bit [i*NUM_LAYERS+j] set if layers i and j (i<j) overlapped in the last completed frame. Bits with i>=j are always 0.
- collide_irq  out  1  one-cycle pulse in the cycle after frame_start, when the newly published collide_flags is nonzero.

Behaviour:
- Reset (clrn low, asynchronous): rgb_out = BG_COLOR; rgb_valid = 0; collide_flags = 0; collide_irq = 0; accumulator and pipeline registers = 0. Release is synchronous to the next clk edge.
- Effective visibility: vis[i] = layer_on[i] & layer_enable[i] & ~(KEY_EN & color_i == KEY_COLOR).
- Stage 1 (cycle N+1): register vis, all colours and video_on.
- Stage 2 (cycle N+2): rgb_out = colour of the lowest-index visible layer; if no layer is visible or video_on is 0, rgb_out = BG_COLOR. rgb_valid = stage-1 video_on.
- Latency: exactly 2 clk from input to rgb_out/rgb_valid. Throughput: one pixel per clock, no stalls.
- Collision accumulation: each cycle that stage-1 video_on = 1, acc[i][j] |= s1_vis[i] & s1_vis[j] for all i<j. Nothing accumulates while video_on = 0.
- On frame_start:
  - collide_flags <= acc | the pair term from the current stage-1 pixel, so no in-flight pixel is lost.
  - acc <= 0.
  - collide_irq <= (that published value != 0).
  - frame_start takes precedence over accumulation: the stage-1 pixel that cycle goes only into the published flags.
- collide_flags holds its value until the next frame_start. collide_irq is high for exactly one cycle.
- Back-to-back frame_start pulses: each one publishes and clears; the second publishes only pixels accumulated between the two pulses.
- frame_start during reset is ignored.
- Reset mid-frame: the accumulator and flags are cleared; the first frame_start after reset publishes a partial frame.
- layer_enable changes take effect on the next input pixel. There is no glitch-free guarantee mid-pixel.

Test Plan:
- Reset then idle: clrn low 3 cycles, all inputs 0 -> rgb_out = 12'h000, rgb_valid = 0, collide_flags = 0 throughout and after release.
- Priority and latency: video_on = 1, layer_on = 5'b00110, colours L1 = 12'hF00, L2 = 12'h0F0 at cycle N -> rgb_out = 12'hF00, rgb_valid = 1 at N+2. Then clear layer_enable[1] -> rgb_out = 12'h0F0 two cycles later.
- Colour key: L0 on with colour 12'hF0F, L4 on with 12'h00F -> rgb_out = 12'h00F. With KEY_EN = 0 build -> rgb_out = 12'hF0F.
- Collision publish:
  - L1 and L3 both on for one pixel in frame k -> after frame_start, bit [1*5+3] = bit 8 set, collide_irq pulses once.
  - Next frame with no overlap -> flags = 0, no irq.
- Boundary:
  - Overlap pixel in stage 1 on the same cycle as frame_start -> flag appears in that publish, not the next frame.
  - Overlap with video_on = 0 -> no flag.
- Reset mid-frame: accumulate an L0/L2 overlap, pulse clrn low mid-frame -> collide_flags = 0 immediately. The next frame_start with no new overlap publishes 0.
